// File: rtl/mips_test_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mips_test_sequencer
//  Purpose  : Drives one self-test of a small MIPS core.
//             1. Streams a program image into the core's memory.
//             2. Releases the core from reset.
//             3. Waits for HALTED, or aborts once the cycle budget expires.
//             4. Reads back a table of (address, expected word) pairs and
//                reports pass/fail.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk1, reset            clock; synchronous active-high reset
//    start                  launch a sequence (honoured in IDLE/DONE only)
//    ld_valid/ld_ready      program-load handshake
//    ld_addr/ld_data/ld_last  program word, its address, final-word flag
//    chk_we/chk_idx/chk_en  check-table write port (enable bit per entry)
//    chk_addr/chk_exp       check address and expected word
//    mem_we/mem_re          memory write/read strobes
//    mem_addr/mem_wdata     memory address and write data
//    mem_rdata              read data, valid one cycle after mem_re
//    core_rst               holds the core in reset (low only in RUN)
//    core_halted            HALTED flag from the core
//    busy/done/pass/timeout status flags
//    fail_idx/cycles        first failing entry; RUN cycle count
// ============================================================================
module mips_test_sequencer #(
    parameter  int AW      = 10,
    parameter  int DW      = 32,
    parameter  int N_CHK   = 4,
    parameter  int TIMEOUT = 1000,
    localparam int CW      = (N_CHK > 1) ? $clog2(N_CHK) : 1,
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    input  logic          chk_we,
    input  logic [CW-1:0] chk_idx,
    input  logic          chk_en,
    input  logic [AW-1:0] chk_addr,
    input  logic [DW-1:0] chk_exp,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_rst,
    input  logic          core_halted,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] fail_idx,
    output logic [TW-1:0] cycles
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CHK_RD  = 3'd3;
    localparam logic [2:0] S_CHK_CMP = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [TW-1:0] c_timeout  = TW'(TIMEOUT);
    localparam logic [CW-1:0] c_last_idx = CW'(N_CHK - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;

    // Check table
    logic [AW-1:0] r_chk_addr [N_CHK];
    logic [DW-1:0] r_chk_exp  [N_CHK];
    logic [N_CHK-1:0] r_chk_en;

    // Load write pipeline: one registered write per accepted beat
    logic          r_mem_we;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic          r_last_pend;

    logic [CW-1:0] r_idx;
    logic          r_pass;
    logic          r_timeout;
    logic [CW-1:0] r_fail_idx;
    logic [TW-1:0] r_cycles;

    logic          w_start_ok;
    logic          w_ld_acc;
    logic          w_idx_last;
    logic          w_mismatch;
    logic          w_cfg_ok;
    logic [TW-1:0] w_cycles_nxt;

    always_comb begin
        w_cfg_ok     = (r_state == S_IDLE) || (r_state == S_DONE);
        w_start_ok   = w_cfg_ok && start;
        w_idx_last   = (r_idx == c_last_idx);
        w_mismatch   = (mem_rdata != r_chk_exp[r_idx]);
        w_cycles_nxt = (r_cycles == c_timeout) ? r_cycles : r_cycles + TW'(1);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ld_ready    = 1'b0;
        w_ld_acc    = 1'b0;
        mem_re      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        core_rst    = 1'b1;
        mem_addr    = r_wr_addr;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy = 1'b1;
                // Once the final beat is taken, stop accepting and spend
                // this cycle on its write before releasing the core.
                ld_ready = !r_last_pend;
                w_ld_acc = ld_valid && !r_last_pend;
                if (r_last_pend) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                core_rst = 1'b0;
                // Halt takes priority over a coincident timeout.
                if (core_halted) begin
                    w_state_nxt = S_CHK_RD;
                end else if (w_cycles_nxt == c_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_CHK_RD: begin
                busy     = 1'b1;
                mem_addr = r_chk_addr[r_idx];
                if (r_chk_en[r_idx]) begin
                    mem_re      = 1'b1;
                    w_state_nxt = S_CHK_CMP;
                end else if (w_idx_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_CHK_CMP: begin
                busy = 1'b1;
                if (w_mismatch || w_idx_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CHK_RD;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = S_LOAD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_last_pend <= 1'b0;
            r_idx       <= '0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_idx  <= '0;
            r_cycles    <= '0;
            r_chk_en    <= '0;
        end else begin
            r_mem_we <= w_ld_acc;
            if (w_ld_acc) begin
                r_wr_addr <= ld_addr;
                r_wr_data <= ld_data;
            end

            if (w_state_nxt != S_LOAD) begin
                r_last_pend <= 1'b0;
            end else if (w_ld_acc && ld_last) begin
                r_last_pend <= 1'b1;
            end

            if (w_cfg_ok && chk_we) begin
                r_chk_en[chk_idx] <= chk_en;
            end

            if (w_start_ok) begin
                r_pass     <= 1'b0;
                r_timeout  <= 1'b0;
                r_fail_idx <= '0;
                r_cycles   <= '0;
            end

            case (r_state)
                S_RUN: begin
                    r_cycles <= w_cycles_nxt;
                    if (core_halted) begin
                        r_idx <= '0;
                    end else if (w_cycles_nxt == c_timeout) begin
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end
                end
                S_CHK_RD: begin
                    if (!r_chk_en[r_idx]) begin
                        if (w_idx_last) r_pass <= 1'b1;
                        else            r_idx  <= r_idx + CW'(1);
                    end
                end
                S_CHK_CMP: begin
                    if (w_mismatch) begin
                        r_fail_idx <= r_idx;
                        r_pass     <= 1'b0;
                    end else if (w_idx_last) begin
                        r_pass <= 1'b1;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Table payload needs no reset: entries are qualified by r_chk_en.
    always_ff @(posedge clk1) begin
        if (w_cfg_ok && chk_we) begin
            r_chk_addr[chk_idx] <= chk_addr;
            r_chk_exp[chk_idx]  <= chk_exp;
        end
    end

    always_comb begin
        mem_we    = r_mem_we;
        mem_wdata = r_wr_data;
        pass      = r_pass;
        timeout   = r_timeout;
        fail_idx  = r_fail_idx;
        cycles    = r_cycles;
    end

endmodule
`default_nettype wire

// File: doc/mips_test_sequencer.md
MIPS_TEST_SEQUENCER -- requirements
Module: mips_test_sequencer

Interface
REQ-001 Parameter AW, default 10: memory word-address width.
REQ-002 Parameter DW, default 32: memory data width.
REQ-003 Parameter N_CHK, default 4: number of result-check entries; CW = max(1, clog2(N_CHK)).
REQ-004 Parameter TIMEOUT, default 1000: maximum RUN cycles before abort; TW = clog2(TIMEOUT+1).
REQ-005 The block SHALL use one clock and one reset: clk1 (input, 1), all logic on its rising edge; reset (input, 1), synchronous, active-high.
REQ-006 start  input  1  launch a test sequence.
REQ-007 ld_valid / ld_ready  input / output  1 / 1  program-load handshake.
REQ-008 ld_addr / ld_data / ld_last  input  AW / DW / 1  program word, its address, and the final-word flag.
REQ-009 chk_we / chk_idx / chk_en  input  1 / CW / 1  write enable, entry index, and entry enable for the check table.
REQ-010 chk_addr / chk_exp  input  AW / DW  check address and expected word.
REQ-011 mem_we / mem_re / mem_addr / mem_wdata  output  1 / 1 / AW / DW  core memory access port.
REQ-012 mem_rdata  input  DW  read data, valid one cycle after mem_re.
REQ-013 core_rst  output  1  holds the core (PC=0, HALTED=0, TAKEN_BRANCH=0) while high.
REQ-014 core_halted  input  1  HALTED flag from the core.
REQ-015 busy / done / pass / timeout  output  1 each  status flags.
REQ-016 fail_idx / cycles  output  CW / TW  first failing check index, and RUN cycle count.

Function
REQ-017 The block SHALL implement FSM states IDLE, LOAD, RUN, CHK_RD, CHK_CMP and DONE.
REQ-018 start SHALL be honoured only in IDLE or DONE; it moves the FSM to LOAD and clears done, pass, timeout, fail_idx and cycles; start in any other state SHALL be ignored.
REQ-019 busy SHALL be 1 exactly in LOAD, RUN, CHK_RD and CHK_CMP; core_rst SHALL be 1 in every state except RUN.
REQ-020 In LOAD, ld_ready SHALL be 1; each beat with ld_valid&&ld_ready SHALL produce mem_we=1 with the registered ld_addr/ld_data on the next cycle (latency 1).
REQ-021 Accepting a beat with ld_last=1 SHALL move the FSM to RUN after that beat's write cycle.
REQ-022 In RUN, cycles SHALL increment by 1 per clock, saturating at TIMEOUT.
REQ-023 In RUN, core_halted=1 SHALL move the FSM to CHK_RD with the check index at 0.
REQ-024 In RUN, if cycles reaches TIMEOUT with core_halted=0, the FSM SHALL go to DONE with timeout=1 and pass=0.
REQ-025 If core_halted and the timeout condition occur in the same cycle, halted SHALL win.
REQ-026 The check table SHALL be writable only in IDLE or DONE; chk_we in any other state SHALL be ignored.
REQ-027 In CHK_RD, a disabled entry SHALL be skipped in 1 cycle; an enabled entry SHALL drive mem_re=1 with mem_addr=chk_addr[i] and then go to CHK_CMP.
REQ-028 In CHK_CMP, mem_rdata != chk_exp[i] SHALL set fail_idx=i and pass=0, and move to DONE (stop at first mismatch).
REQ-029 In CHK_CMP on a match, the FSM SHALL return to CHK_RD with i+1.
REQ-030 After entry N_CHK-1 with no mismatch, the FSM SHALL go to DONE with pass=1; if all entries are disabled, pass SHALL be 1.
REQ-031 In DONE, done=1 and all flags SHALL hold until start or reset.
REQ-032 mem_we and mem_re SHALL never be asserted in the same cycle, and neither SHALL be asserted outside LOAD/CHK_RD.

Reset
REQ-033 reset SHALL force IDLE, clear the check-table enables, and drive ld_ready=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, core_rst=1, busy=0, done=0, pass=0, timeout=0, fail_idx=0, cycles=0.
REQ-034 reset asserted mid-LOAD or mid-RUN SHALL abort on the next edge with no further memory access.

Verification
REQ-035 Load 8 words (ADDI R1,R0,120 ... HLT) at addresses 0..7, preset Mem[120]=85, check entry 0 = (121, 130) -> 8 mem_we pulses, core halts, done=1, pass=1.
REQ-036 Same program with check entry 0 = (121, 131) -> done=1, pass=0, fail_idx=0.
REQ-037 Program without HLT, TIMEOUT=50 -> cycles=50, timeout=1, pass=0, done=1.
REQ-038 Check entries 0 and 2 enabled, entry 2 mismatching -> exactly 2 mem_re pulses, fail_idx=2.
REQ-039 reset asserted after 3 of 8 load beats -> next cycle busy=0, core_rst=1, no further mem_we; start then reruns cleanly.
REQ-040 ld_valid toggled 1/0 each cycle during LOAD, plus start pulsed in RUN -> all 8 words written once, start ignored.
